// File: rtl/freq_gen.sv
// Programmable square-wave source: 4-digit BCD value scaled by a decade
// select, generated by an error-free accumulator against CLK_HZ/2.
module freq_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [1:0]  select,
  input  logic [15:0] digits,
  input  logic        load,
  output logic        sigout,
  output logic        busy,
  output logic        running,
  output logic        modeout,
  output logic        bcderr
);

  localparam logic [31:0] HALF = 32'(CLK_HZ / 2);

  typedef enum logic [2:0] {IDLE, CONV, SCALE, CHECK, RUN} state_t;

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic [15:0] dig_h;
  logic [1:0]  sel_h;
  logic [23:0] f;
  logic [31:0] acc;
  logic [31:0] sum;
  logic [3:0]  digit;
  logic        dig_bad;
  logic        f_over;

  // Current BCD digit, most significant first
  always_comb begin
    digit = dig_h[3:0];
    case (cnt)
      2'd0: digit = dig_h[15:12];
      2'd1: digit = dig_h[11:8];
      2'd2: digit = dig_h[7:4];
      default: digit = dig_h[3:0];
    endcase
  end

  assign dig_bad = (digit > 4'd9);
  assign f_over  = ({8'd0, f} > HALF);
  assign sum     = acc + {8'd0, f};
  assign busy    = (state == CONV) || (state == SCALE) || (state == CHECK);
  assign running = (state == RUN);

  // State register; reset beats load
  always_ff @(posedge sysclk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; a load restarts conversion from any state
  always_comb begin
    state_n = state;
    if (load) begin
      state_n = CONV;
    end else begin
      case (state)
        IDLE:  state_n = IDLE;
        CONV: begin
          if (dig_bad)          state_n = IDLE;
          else if (cnt == 2'd3) state_n = (sel_h == 2'd0) ? CHECK : SCALE;
        end
        SCALE: if (cnt == sel_h - 2'd1) state_n = CHECK;
        CHECK: begin
          if (f == 24'd0 || f_over) state_n = IDLE;
          else                      state_n = RUN;
        end
        RUN:     state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath: capture, BCD->binary, decade scaling, flag and accumulator update
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      cnt     <= 2'd0;
      dig_h   <= 16'd0;
      sel_h   <= 2'd0;
      f       <= 24'd0;
      acc     <= 32'd0;
      sigout  <= 1'b0;
      modeout <= 1'b0;
      bcderr  <= 1'b0;
    end else if (load) begin
      cnt     <= 2'd0;
      dig_h   <= digits;
      sel_h   <= select;
      f       <= 24'd0;
      sigout  <= 1'b0;
      modeout <= 1'b0;
      bcderr  <= 1'b0;
    end else begin
      case (state)
        CONV: begin
          if (dig_bad) begin
            bcderr <= 1'b1;
            sigout <= 1'b0;
            cnt    <= 2'd0;
          end else begin
            f   <= f * 24'd10 + {20'd0, digit};
            cnt <= cnt + 2'd1;
          end
        end
        SCALE: begin
          f   <= f * 24'd10;
          cnt <= (cnt == sel_h - 2'd1) ? 2'd0 : cnt + 2'd1;
        end
        CHECK: begin
          if (f != 24'd0 && f_over) modeout <= 1'b1;
          acc <= 32'd0;
        end
        RUN: begin
          // Bresenham step: acc stays below HALF, so no wrap
          if (sum >= HALF) begin
            acc    <= sum - HALF;
            sigout <= ~sigout;
          end else begin
            acc <= sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen at CLK_HZ=1000 (HALF=500).
module tb_freq_gen;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [1:0]  select;
  logic [15:0] digits;
  logic        load;
  logic        sigout, busy, running, modeout, bcderr;

  int cmp_cnt = 0;
  int err_cnt = 0;

  freq_gen #(.CLK_HZ(1000)) dut (
    .sysclk(sysclk), .rst(rst), .select(select), .digits(digits), .load(load),
    .sigout(sigout), .busy(busy), .running(running), .modeout(modeout), .bcderr(bcderr)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [1:0] s);
    digits = d; select = s; load = 1'b1;
    tick();
    load = 1'b0;
    digits = 16'hFFFF; select = 2'b11;  // later input changes must be ignored
  endtask

  // Busy samples starting at the sample right after the load edge
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 50) begin n++; tick(); end
  endtask

  task automatic wait_toggle(output int k);
    logic last;
    last = sigout; k = 0;
    while (sigout == last && k < 200) begin k++; tick(); end
  endtask

  task automatic count_changes(input int cycles, output int ch);
    logic last;
    ch = 0; last = sigout;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sigout != last) ch++;
      last = sigout;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; digits = 16'h0050; select = 2'b00;
    repeat (3) tick();
    cmp_cnt++;
    if ({sigout, busy, running, modeout, bcderr} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_hold got=%b exp=00000", {sigout, busy, running, modeout, bcderr});
    end
    load = 1'b0; rst = 1'b1;
    tick();
    cmp_cnt++;
    if ({sigout, busy, running, modeout, bcderr} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_release got=%b exp=00000", {sigout, busy, running, modeout, bcderr});
    end
  endtask

  task automatic test_exact();
    int n, k;
    do_load(16'h0050, 2'b00);
    wait_busy(n);
    cmp_cnt++;
    if (n !== 5 || running !== 1'b1) begin
      err_cnt++; $display("FAIL exact_latency busy=%0d run=%b exp=5/1", n, running);
    end
    wait_toggle(k);
    cmp_cnt++;
    if (k !== 10 || sigout !== 1'b1) begin
      err_cnt++; $display("FAIL exact_first got=%0d exp=10", k);
    end
    wait_toggle(k);
    cmp_cnt++;
    if (k !== 10) begin err_cnt++; $display("FAIL exact_period got=%0d exp=10", k); end
  endtask

  task automatic test_fractional();
    int n, toggles, gap, bad;
    logic last, first;
    do_load(16'h0003, 2'b01);
    wait_busy(n);
    cmp_cnt++;
    if (n !== 6) begin err_cnt++; $display("FAIL frac_latency got=%0d exp=6", n); end
    toggles = 0; gap = 0; bad = 0; first = 1'b1; last = sigout;
    for (int i = 0; i < 3000; i++) begin
      tick(); gap++;
      if (sigout != last) begin
        toggles++;
        if (first ? (gap != 17) : (gap != 16 && gap != 17)) bad++;
        first = 1'b0; gap = 0; last = sigout;
      end
    end
    cmp_cnt++;
    if (toggles !== 180) begin err_cnt++; $display("FAIL frac_count got=%0d exp=180", toggles); end
    cmp_cnt++;
    if (bad !== 0) begin err_cnt++; $display("FAIL frac_interval bad=%0d exp=0", bad); end
  endtask

  task automatic test_range();
    int n, ch;
    do_load(16'h0500, 2'b00);
    wait_busy(n);
    count_changes(8, ch);
    cmp_cnt++;
    if (n !== 5 || ch !== 8 || modeout !== 1'b0) begin
      err_cnt++; $display("FAIL range_500 busy=%0d ch=%0d mode=%b exp=5/8/0", n, ch, modeout);
    end
    do_load(16'h0501, 2'b00);
    wait_busy(n);
    tick();
    cmp_cnt++;
    if ({modeout, sigout, running} !== 3'b100) begin
      err_cnt++; $display("FAIL range_501 got=%b exp=100", {modeout, sigout, running});
    end
    do_load(16'h0005, 2'b10);
    wait_busy(n);
    count_changes(8, ch);
    cmp_cnt++;
    if (n !== 7 || ch !== 8 || modeout !== 1'b0) begin
      err_cnt++; $display("FAIL range_5x100 busy=%0d ch=%0d mode=%b exp=7/8/0", n, ch, modeout);
    end
    do_load(16'h0006, 2'b10);
    wait_busy(n);
    cmp_cnt++;
    if (n !== 7 || {modeout, sigout, running} !== 3'b100) begin
      err_cnt++; $display("FAIL range_6x100 busy=%0d got=%b exp=7/100", n, {modeout, sigout, running});
    end
  endtask

  task automatic test_errors();
    int n;
    do_load(16'h00A0, 2'b00);
    wait_busy(n);
    cmp_cnt++;
    if (n !== 3 || bcderr !== 1'b1 || sigout !== 1'b0 || modeout !== 1'b0) begin
      err_cnt++; $display("FAIL bcd_err busy=%0d err=%b sig=%b exp=3/1/0", n, bcderr, sigout);
    end
    do_load(16'h0000, 2'b01);
    cmp_cnt++;
    if (bcderr !== 1'b0) begin err_cnt++; $display("FAIL bcd_clear got=%b exp=0", bcderr); end
    wait_busy(n);
    cmp_cnt++;
    if (n !== 6 || {sigout, busy, running, modeout, bcderr} !== 5'b0) begin
      err_cnt++; $display("FAIL zero busy=%0d got=%b exp=6/00000", n, {sigout, busy, running, modeout, bcderr});
    end
  endtask

  task automatic test_midop();
    int n, k;
    // Load during RUN while sigout is high
    do_load(16'h0500, 2'b00);
    wait_busy(n);
    tick();
    digits = 16'h0050; select = 2'b00; load = 1'b1;
    cmp_cnt++;
    if (sigout !== 1'b1) begin err_cnt++; $display("FAIL midrun_pre got=%b exp=1", sigout); end
    tick(); load = 1'b0;
    cmp_cnt++;
    if (sigout !== 1'b0 || busy !== 1'b1 || running !== 1'b0) begin
      err_cnt++; $display("FAIL midrun_load got=%b%b%b exp=010", sigout, busy, running);
    end
    wait_busy(n);
    wait_toggle(k);
    cmp_cnt++;
    if (n !== 5 || k !== 10) begin err_cnt++; $display("FAIL midrun_new busy=%0d first=%0d exp=5/10", n, k); end
    // Load during CONV replaces the bad digits before they are reached
    do_load(16'h00A0, 2'b00);
    do_load(16'h0050, 2'b00);
    wait_busy(n);
    wait_toggle(k);
    cmp_cnt++;
    if (n !== 5 || bcderr !== 1'b0 || k !== 10) begin
      err_cnt++; $display("FAIL midconv busy=%0d err=%b first=%0d exp=5/0/10", n, bcderr, k);
    end
  endtask

  task automatic test_rst_scale();
    do_load(16'h0001, 2'b11);
    repeat (4) tick();
    cmp_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL scale_pre busy=%b exp=1", busy); end
    rst = 1'b0;
    tick();
    cmp_cnt++;
    if ({sigout, busy, running, modeout, bcderr} !== 5'b0) begin
      err_cnt++; $display("FAIL scale_rst got=%b exp=00000", {sigout, busy, running, modeout, bcderr});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_rst();
    rst = 1'b0; digits = 16'h0050; select = 2'b00; load = 1'b1;
    tick();
    load = 1'b0; rst = 1'b1;
    tick();
    cmp_cnt++;
    if ({sigout, busy, running, modeout, bcderr} !== 5'b0) begin
      err_cnt++; $display("FAIL load_rst got=%b exp=00000", {sigout, busy, running, modeout, bcderr});
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; digits = 16'h0; select = 2'b0;
    #1;
    test_reset();
    test_exact();
    test_fractional();
    test_range();
    test_errors();
    test_midop();
    test_rst_scale();
    test_load_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
